mem_bus_arbiter: RTL

- Owns the shared memory-router master port and decides cycle by cycle which requester drives it: CPU, OAM DMA or HDMA.
- Generates the CPU stall (cpu_mem_disable) and the per-master grants.
- Enforces PPU-mode access blocking of OAM and LCD RAM for CPU accesses.
- Sits between the requesters and memory_router, clocked on the main clock.

---
 rtl/mem_bus_arbiter_pkg.sv | 34 +++
 rtl/mem_arb_ppu_block.sv | 36 +++
 rtl/mem_bus_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared definitions for the memory-bus arbiter:
//   - owner_e     : bus owner encoding, also the arbiter state encoding
//   - PPU_MODE_*  : PPU mode numbers as seen on ppu_mode
//   - OAM_* / LCD_RAM_* : inclusive address bounds of the PPU-lockable regions
//   - in_range()  : inclusive address range test
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    OWNER_IDLE   = 2'b00,
    OWNER_CPU    = 2'b01,
    OWNER_OAMDMA = 2'b10,
    OWNER_HDMA   = 2'b11
  } owner_e;

  localparam logic [1:0] PPU_MODE_HBLANK   = 2'd0;
  localparam logic [1:0] PPU_MODE_VBLANK   = 2'd1;
  localparam logic [1:0] PPU_MODE_OAM_SCAN = 2'd2;
  localparam logic [1:0] PPU_MODE_TRANSFER = 2'd3;

  localparam logic [15:0] OAM_LO     = 16'hFE00;
  localparam logic [15:0] OAM_HI     = 16'hFE9F;
  localparam logic [15:0] LCD_RAM_LO = 16'h8000;
  localparam logic [15:0] LCD_RAM_HI = 16'h9FFF;

  function automatic logic in_range(input logic [15:0] addr,
                                    input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/mem_arb_ppu_block.sv
// -----------------------------------------------------------------------------
// mem_arb_ppu_block
// Combinational PPU access lock for CPU cycles. While the PPU is scanning OAM
// or transferring to the LCD, the CPU may not touch OAM; during transfer it
// may not touch LCD RAM either. The router answers blocked reads with 0xFF and
// drops blocked writes.
// Ports:
//   owner    in  current bus owner (lock only applies when the CPU owns it)
//   addr     in  CPU address
//   ppu_mode in  0 hblank, 1 vblank, 2 OAM scan, 3 transfer
//   blocked  out CPU access hits a locked region
// -----------------------------------------------------------------------------
module mem_arb_ppu_block
  import mem_bus_arbiter_pkg::*;
(
  input  owner_e      owner,
  input  logic [15:0] addr,
  input  logic [1:0]  ppu_mode,
  output logic        blocked
);

  logic oam_hit;
  logic lcd_hit;
  logic oam_locked;
  logic lcd_locked;

  always_comb begin
    oam_hit    = in_range(addr, OAM_LO, OAM_HI);
    lcd_hit    = in_range(addr, LCD_RAM_LO, LCD_RAM_HI);
    oam_locked = (ppu_mode == PPU_MODE_OAM_SCAN) || (ppu_mode == PPU_MODE_TRANSFER);
    lcd_locked = (ppu_mode == PPU_MODE_TRANSFER);
    blocked    = (owner == OWNER_CPU) &&
                 ((oam_hit && oam_locked) || (lcd_hit && lcd_locked));
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Decides cycle by cycle which requester (CPU, OAM DMA, HDMA) drives the shared
// memory-router master port. Priority HDMA > OAMDMA > CPU; DMA bursts are
// locked until LAST, a dropped request (abort) or BURST_MAX beats (forced
// release). After a burst ends the CPU, if waiting, is served first.
//
// Optional feature macro: ARB_CPU_FAIRNESS_EN
//   When defined, a starve counter tracks CPU wait cycles; on reaching
//   CPU_STARVE_MAX the running burst is suspended for exactly one CPU cycle
//   and then resumes with its beat count intact.
//
// Ports:
//   clk, rst_n                 main clock, asynchronous active-low reset
//   cpu_req, cpu_addr          CPU request and address (address for PPU lock)
//   cpu_gnt, cpu_mem_disable   CPU owns bus / CPU stall (DMA owns bus)
//   cpu_blocked                CPU access hits PPU-locked region
//   oamdma_req/last/gnt        OAM DMA beat request, final beat, grant
//   hdma_req/last/gnt          HDMA beat request, final beat, grant
//   ppu_mode                   PPU mode
//   bus_owner                  00 idle, 01 CPU, 10 OAMDMA, 11 HDMA
//   beat_count                 granted beats in current DMA burst (sat. 255)
//   abort                      one-cycle pulse on aborted/timed-out burst
// -----------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int BURST_MAX      = 160,
  parameter int CPU_STARVE_MAX = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  output logic        cpu_gnt,
  output logic        cpu_mem_disable,
  output logic        cpu_blocked,
  input  logic        oamdma_req,
  input  logic        oamdma_last,
  output logic        oamdma_gnt,
  input  logic        hdma_req,
  input  logic        hdma_last,
  output logic        hdma_gnt,
  input  logic [1:0]  ppu_mode,
  output logic [1:0]  bus_owner,
  output logic [7:0]  beat_count,
  output logic        abort
);

  owner_e     owner_reg, owner_next;
  logic [7:0] beat_count_reg, beat_count_next;
  // done: the final beat (LAST or BURST_MAX) has been counted; the owner keeps
  // the bus for this one cycle so the completed count is visible, then the
  // arbiter re-arbitrates.
  logic       done_reg, done_next;
  logic       abort_reg, abort_next;
  logic       cpu_gnt_reg, oamdma_gnt_reg, hdma_gnt_reg, mem_disable_reg;

  logic       dma_req;
  logic       dma_last;
  logic [7:0] beat_inc;
  logic       burst_hit;
  owner_e     idle_pick;
  owner_e     rearb_owner;

`ifdef ARB_CPU_FAIRNESS_EN
  logic [15:0] starve_reg, starve_next;
  logic        suspend_reg, suspend_next;
  owner_e      resume_owner_reg, resume_owner_next;
  logic        starve_hit;
`endif

  // Request/last of whichever DMA currently owns the bus.
  always_comb begin
    dma_req  = 1'b0;
    dma_last = 1'b0;
    case (owner_reg)
      OWNER_OAMDMA: begin
        dma_req  = oamdma_req;
        dma_last = oamdma_last;
      end
      OWNER_HDMA: begin
        dma_req  = hdma_req;
        dma_last = hdma_last;
      end
      default: begin
        dma_req  = 1'b0;
        dma_last = 1'b0;
      end
    endcase
  end

  always_comb begin
    beat_inc  = (beat_count_reg == 8'hFF) ? 8'hFF : beat_count_reg + 8'd1;
    burst_hit = (int'(beat_inc) >= BURST_MAX);

    // Plain priority used from IDLE.
    if (hdma_req)        idle_pick = OWNER_HDMA;
    else if (oamdma_req) idle_pick = OWNER_OAMDMA;
    else if (cpu_req)    idle_pick = OWNER_CPU;
    else                 idle_pick = OWNER_IDLE;

    // After a burst ends the CPU goes first, guaranteeing it a slot between
    // back-to-back bursts.
    if (cpu_req)         rearb_owner = OWNER_CPU;
    else if (hdma_req)   rearb_owner = OWNER_HDMA;
    else if (oamdma_req) rearb_owner = OWNER_OAMDMA;
    else                 rearb_owner = OWNER_IDLE;
  end

`ifdef ARB_CPU_FAIRNESS_EN
  always_comb begin
    starve_next = starve_reg;
    if (cpu_gnt_reg) begin
      starve_next = 16'd0;
    end else if (cpu_req && (int'(starve_reg) < CPU_STARVE_MAX)) begin
      starve_next = starve_reg + 16'd1;
    end
    // Fires on the cycle whose wait brings the counter to the limit.
    starve_hit = cpu_req && !cpu_gnt_reg && ((int'(starve_reg) + 1) >= CPU_STARVE_MAX);
  end
`endif

  always_comb begin
    owner_next      = owner_reg;
    beat_count_next = beat_count_reg;
    done_next       = done_reg;
    abort_next      = 1'b0;
`ifdef ARB_CPU_FAIRNESS_EN
    suspend_next      = suspend_reg;
    resume_owner_next = resume_owner_reg;
`endif

    case (owner_reg)
      OWNER_IDLE: begin
        owner_next      = idle_pick;
        beat_count_next = 8'd0;
        done_next       = 1'b0;
      end

      OWNER_CPU: begin
`ifdef ARB_CPU_FAIRNESS_EN
        if (suspend_reg) begin
          // Single fairness slot is over: hand the bus back, count intact.
          owner_next   = resume_owner_reg;
          suspend_next = 1'b0;
        end else
`endif
        begin
          if (hdma_req)        owner_next = OWNER_HDMA;
          else if (oamdma_req) owner_next = OWNER_OAMDMA;
          else if (!cpu_req)   owner_next = OWNER_IDLE;
          if (owner_next != owner_reg) beat_count_next = 8'd0;
        end
      end

      OWNER_OAMDMA, OWNER_HDMA: begin
        if (done_reg) begin
          owner_next      = rearb_owner;
          beat_count_next = 8'd0;
          done_next       = 1'b0;
        end else if (!dma_req) begin
          // Request vanished mid-burst without LAST.
          abort_next      = 1'b1;
          owner_next      = rearb_owner;
          beat_count_next = 8'd0;
        end else begin
          beat_count_next = beat_inc;
          if (dma_last) begin
            // LAST wins over a simultaneous BURST_MAX hit: clean completion.
            done_next = 1'b1;
          end else if (burst_hit) begin
            done_next  = 1'b1;
            abort_next = 1'b1;
          end
`ifdef ARB_CPU_FAIRNESS_EN
          else if (starve_hit) begin
            owner_next        = OWNER_CPU;
            suspend_next      = 1'b1;
            resume_owner_next = owner_reg;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg       <= OWNER_IDLE;
      beat_count_reg  <= 8'd0;
      done_reg        <= 1'b0;
      abort_reg       <= 1'b0;
      cpu_gnt_reg     <= 1'b0;
      oamdma_gnt_reg  <= 1'b0;
      hdma_gnt_reg    <= 1'b0;
      mem_disable_reg <= 1'b0;
`ifdef ARB_CPU_FAIRNESS_EN
      starve_reg       <= 16'd0;
      suspend_reg      <= 1'b0;
      resume_owner_reg <= OWNER_IDLE;
`endif
    end else begin
      owner_reg       <= owner_next;
      beat_count_reg  <= beat_count_next;
      done_reg        <= done_next;
      abort_reg       <= abort_next;
      cpu_gnt_reg     <= (owner_next == OWNER_CPU);
      oamdma_gnt_reg  <= (owner_next == OWNER_OAMDMA);
      hdma_gnt_reg    <= (owner_next == OWNER_HDMA);
      mem_disable_reg <= (owner_next == OWNER_OAMDMA) || (owner_next == OWNER_HDMA);
`ifdef ARB_CPU_FAIRNESS_EN
      starve_reg       <= starve_next;
      suspend_reg      <= suspend_next;
      resume_owner_reg <= resume_owner_next;
`endif
    end
  end

  mem_arb_ppu_block u_ppu_block (
    .owner    (owner_reg),
    .addr     (cpu_addr),
    .ppu_mode (ppu_mode),
    .blocked  (cpu_blocked)
  );

  assign cpu_gnt         = cpu_gnt_reg;
  assign oamdma_gnt      = oamdma_gnt_reg;
  assign hdma_gnt        = hdma_gnt_reg;
  assign cpu_mem_disable = mem_disable_reg;
  assign bus_owner       = owner_reg;
  assign beat_count      = beat_count_reg;
  assign abort           = abort_reg;

endmodule
